// File: rtl/uart_poll_ctrl_if.sv
// Register-bus port between uart_poll_ctrl (master) and the UART slave.
// Combinational wires only; readdata is valid the cycle after a read strobe.
// No backpressure: every access completes in one cycle.
interface uart_poll_ctrl_if;
    logic [2:0]  uart_address;
    logic        uart_chipselect;
    logic        uart_begintransfer;
    logic        uart_read_n;
    logic        uart_write_n;
    logic [15:0] uart_writedata;
    logic [15:0] uart_readdata;

    modport master (
        output uart_address, uart_chipselect, uart_begintransfer,
               uart_read_n, uart_write_n, uart_writedata,
        input  uart_readdata
    );

    modport slave (
        input  uart_address, uart_chipselect, uart_begintransfer,
               uart_read_n, uart_write_n, uart_writedata,
        output uart_readdata
    );
endinterface

// File: rtl/uart_poll_ctrl.sv
// UART poll sequencer: TX FIFO drain, RX capture, optional error clear (UART_POLL_CTRL_ERR_CLR_EN).
// Poll->decision 2 cycles; RX byte visible 4 cycles after poll strobe; TX write on 3rd cycle.
// tx_ready drops when FIFO full; a held RX byte blocks further RX reads until rx_ready.
module uart_poll_ctrl #(
    parameter int TX_DEPTH    = 8,
    parameter int POLL_CYCLES = 16
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [$clog2(TX_DEPTH+1)-1:0] tx_level,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    input  logic                          uart_irq,
    uart_poll_ctrl_if.master              uart,
    output logic                          err_pulse,
    output logic [4:0]                    err_flags
);
    localparam int PTR_W = $clog2(TX_DEPTH);
    localparam int LVL_W = $clog2(TX_DEPTH + 1);
    localparam int CNT_W = $clog2(POLL_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_POLL   = 3'd1,
        S_EVAL   = 3'd2,
        S_RX_RD  = 3'd3,
        S_RX_CAP = 3'd4,
        S_TX_WR  = 3'd5
`ifdef UART_POLL_CTRL_ERR_CLR_EN
        ,
        S_ERR_CLR = 3'd6
`endif
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [7:0]         r_mem [TX_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LVL_W-1:0]   r_level;
    logic [7:0]         r_rx_data;
    logic               r_rx_valid;
    logic               w_push;
    logic               w_pop;

    assign tx_ready = (r_level != LVL_W'(TX_DEPTH));
    assign tx_level = r_level;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign w_push   = tx_valid && tx_ready;

    // Bus strobes decode straight from the state so reset idles the bus immediately.
    always_comb begin
        w_next                  = r_state;
        w_pop                   = 1'b0;
        uart.uart_address       = 3'd0;
        uart.uart_chipselect    = 1'b0;
        uart.uart_begintransfer = 1'b0;
        uart.uart_read_n        = 1'b1;
        uart.uart_write_n       = 1'b1;
        uart.uart_writedata     = 16'h0000;
        case (r_state)
            S_IDLE: begin
                if (r_cnt == CNT_W'(POLL_CYCLES - 1) || uart_irq)
                    w_next = S_POLL;
            end
            S_POLL: begin
                uart.uart_address       = 3'd2;
                uart.uart_chipselect    = 1'b1;
                uart.uart_begintransfer = 1'b1;
                uart.uart_read_n        = 1'b0;
                w_next                  = S_EVAL;
            end
            S_EVAL: begin
                w_next = S_IDLE;
`ifdef UART_POLL_CTRL_ERR_CLR_EN
                if (|uart.uart_readdata[4:0])
                    w_next = S_ERR_CLR;
                else
`endif
                if (uart.uart_readdata[7] && !r_rx_valid)
                    w_next = S_RX_RD;
                else if (uart.uart_readdata[6] && r_level != '0)
                    w_next = S_TX_WR;
            end
            S_RX_RD: begin
                uart.uart_address       = 3'd0;
                uart.uart_chipselect    = 1'b1;
                uart.uart_begintransfer = 1'b1;
                uart.uart_read_n        = 1'b0;
                w_next                  = S_RX_CAP;
            end
            S_RX_CAP: begin
                w_next = S_POLL;
            end
            S_TX_WR: begin
                uart.uart_address       = 3'd1;
                uart.uart_chipselect    = 1'b1;
                uart.uart_begintransfer = 1'b1;
                uart.uart_write_n       = 1'b0;
                uart.uart_writedata     = {8'h00, r_mem[r_rd_ptr]};
                w_pop                   = 1'b1;
                w_next                  = S_POLL;
            end
`ifdef UART_POLL_CTRL_ERR_CLR_EN
            S_ERR_CLR: begin
                uart.uart_address       = 3'd2;
                uart.uart_chipselect    = 1'b1;
                uart.uart_begintransfer = 1'b1;
                uart.uart_write_n       = 1'b0;
                w_next                  = S_POLL;
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_next == S_IDLE)
                r_cnt <= r_cnt + 1'b1;
            else
                r_cnt <= '0;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= tx_data;
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
        end else if (r_state == S_RX_CAP) begin
            r_rx_data  <= uart.uart_readdata[7:0];
            r_rx_valid <= 1'b1;
        end else if (r_rx_valid && rx_ready) begin
            r_rx_valid <= 1'b0;
        end
    end

`ifdef UART_POLL_CTRL_ERR_CLR_EN
    logic [4:0] r_stat_err;
    logic [4:0] r_err_flags;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_stat_err  <= 5'h00;
            r_err_flags <= 5'h00;
        end else begin
            if (r_state == S_EVAL)
                r_stat_err <= uart.uart_readdata[4:0];
            if (r_state == S_ERR_CLR)
                r_err_flags <= r_stat_err;
        end
    end

    assign err_pulse = (r_state == S_ERR_CLR);
    assign err_flags = r_err_flags;
`else
    assign err_pulse = 1'b0;
    assign err_flags = 5'h00;
`endif

endmodule
